data_mem_port: RTL and testbench

//  Load/store unit between the XB stage and the data-memory bus; the consumer end of the decoder's
//  dm_be / dm_we / mem_is_signed controls. Issues one word-aligned bus transaction per memory op,

---
 rtl/data_mem_port.sv | 159 +++++++++++++++
 tb/tb_data_mem_port.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_port.sv
// data_mem_port: load/store unit between XB stage and data-memory bus.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module data_mem_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_kill,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic        req_we,
    input  logic        req_is_signed,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_error,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        accept;
    logic        expire;
    logic [1:0]  off_q;
    logic        sgn_q;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_val;

    function automatic logic is_byte(input logic [3:0] be);
        return (be == 4'b0001) || (be == 4'b0010) ||
               (be == 4'b0100) || (be == 4'b1000);
    endfunction

    function automatic logic is_half(input logic [3:0] be);
        return (be == 4'b0011) || (be == 4'b1100);
    endfunction

    assign accept      = req_valid & ~req_kill & (req_be != 4'b0000);
    assign rdata_valid = (state == RESP);

    // Replicate store data onto every byte lane it may land in
    always_comb begin
        lane_wdata = req_wdata;
        unique case (1'b1)
            is_byte(req_be): lane_wdata = {4{req_wdata[7:0]}};
            is_half(req_be): lane_wdata = {2{req_wdata[15:0]}};
            default:         lane_wdata = req_wdata;
        endcase
    end

    // Shift the read word down to bit 0 and extend to 32 bits
    always_comb begin
        shifted  = mem_rdata >> {off_q, 3'b000};
        load_val = shifted;
        unique case (1'b1)
            is_byte(mem_be):
                load_val = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
            is_half(mem_be):
                load_val = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
            default:
                load_val = shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] timeout_cnt;
    logic       err_q;

    assign expire    = (timeout_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign bus_error = (state == RESP) & err_q;

    // Count BUSY cycles; flag the response as an error on expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            if (state == IDLE && accept)
                timeout_cnt <= 8'd0;
            else if (state == BUSY)
                timeout_cnt <= timeout_cnt + 8'd1;
            err_q <= (state == BUSY) & expire & ~mem_ack;
        end
    end
`else
    assign expire    = 1'b0;
    assign bus_error = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM next state and pipeline stall
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stall    = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack | expire)
                    state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus request launch, hold and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'd0;
            off_q     <= 2'd0;
            sgn_q     <= 1'b0;
            rdata     <= 32'd0;
        end else if (state == IDLE && accept) begin
            mem_req   <= 1'b1;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= req_be;
            mem_we    <= req_we;
            mem_wdata <= lane_wdata;
            off_q     <= req_addr[1:0];
            sgn_q     <= req_is_signed;
        end else if (state == BUSY && (mem_ack | expire)) begin
            mem_req <= 1'b0;
            rdata   <= (mem_ack & ~mem_we) ? load_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed checks for data_mem_port.
// Timeout case is exercised when LSU_TIMEOUT_EN is defined.
module tb_data_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_kill;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic        req_we;
    logic        req_is_signed;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_error;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int fails = 0;

    data_mem_port #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_kill(req_kill),
        .req_addr(req_addr),
        .req_be(req_be),
        .req_we(req_we),
        .req_is_signed(req_is_signed),
        .req_wdata(req_wdata),
        .stall(stall),
        .rdata(rdata),
        .rdata_valid(rdata_valid),
        .bus_error(bus_error),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] addr,
                          input logic [3:0] be, input logic we,
                          input logic sgn, input logic [31:0] wd,
                          input logic [31:0] rd, input int k,
                          input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata);
        int ncyc;
        req_valid     = 1'b1;
        req_kill      = 1'b0;
        req_addr      = addr;
        req_be        = be;
        req_we        = we;
        req_is_signed = sgn;
        req_wdata     = wd;
        #1;
        chk1({tag, " accept stall"}, stall, 1'b1);
        chk1({tag, " accept mem_req"}, mem_req, 1'b0);
        ncyc = 1;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0;
        req_be    = 4'b0000;
        for (int i = 1; i <= k; i++) begin
            mem_ack   = (i == k);
            mem_rdata = (i == k) ? rd : 32'hA5A5_A5A5;
            #1;
            chk1({tag, " busy mem_req"}, mem_req, 1'b1);
            chk({tag, " busy mem_addr"}, mem_addr, exp_addr);
            chk({tag, " busy mem_be"}, {28'd0, mem_be}, {28'd0, be});
            chk1({tag, " busy mem_we"}, mem_we, we);
            chk({tag, " busy mem_wdata"}, mem_wdata, exp_wdata);
            chk1({tag, " busy stall"}, stall, 1'b1);
            chk1({tag, " busy rdata_valid"}, rdata_valid, 1'b0);
            if (stall) ncyc++;
            tick();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk1({tag, " resp rdata_valid"}, rdata_valid, 1'b1);
        chk1({tag, " resp stall"}, stall, 1'b0);
        chk1({tag, " resp mem_req"}, mem_req, 1'b0);
        chk1({tag, " resp bus_error"}, bus_error, 1'b0);
        chk({tag, " resp rdata"}, rdata, exp_rdata);
        chk({tag, " stall cycles"}, 32'(ncyc), 32'(k + 1));
        tick();
        chk1({tag, " post rdata_valid"}, rdata_valid, 1'b0);
        chk({tag, " post rdata hold"}, rdata, exp_rdata);
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_kill      = 1'b0;
        req_addr      = 32'h0;
        req_be        = 4'b0000;
        req_we        = 1'b0;
        req_is_signed = 1'b0;
        req_wdata     = 32'h0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'h0;
        #2;
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk("rst mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk1("rst rdata_valid", rdata_valid, 1'b0);
        chk1("rst bus_error", bus_error, 1'b0);
        chk1("rst stall", stall, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        run_op("lb", 32'h103, 4'b1000, 1'b0, 1'b1, 32'h0, 32'h8011_2233,
               1, 32'h100, 32'h0, 32'hFFFF_FF80);
        run_op("lhu", 32'h202, 4'b1100, 1'b0, 1'b0, 32'h0, 32'hBEEF_1234,
               2, 32'h200, 32'h0, 32'h0000_BEEF);
        run_op("lh", 32'h202, 4'b1100, 1'b0, 1'b1, 32'h0, 32'hBEEF_1234,
               1, 32'h200, 32'h0, 32'hFFFF_BEEF);
        run_op("sb", 32'h301, 4'b0010, 1'b1, 1'b0, 32'h0000_00AB,
               32'h1111_1111, 1, 32'h300, 32'hABAB_ABAB, 32'h0);
        run_op("sw", 32'h304, 4'b1111, 1'b1, 1'b0, 32'h1234_5678,
               32'h0, 1, 32'h304, 32'h1234_5678, 32'h0);
        run_op("sh", 32'h306, 4'b1100, 1'b1, 1'b0, 32'hFFFF_5A5A,
               32'h0, 2, 32'h304, 32'h5A5A_5A5A, 32'h0);
        run_op("lw3", 32'h400, 4'b1111, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF,
               3, 32'h400, 32'h0, 32'hDEAD_BEEF);
        run_op("lb1", 32'h401, 4'b0010, 1'b0, 1'b1, 32'h0, 32'h0000_F700,
               1, 32'h400, 32'h0, 32'hFFFF_FFF7);
        run_op("lbu1", 32'h401, 4'b0010, 1'b0, 1'b0, 32'h0, 32'h0000_F700,
               1, 32'h400, 32'h0, 32'h0000_00F7);

        req_valid = 1'b1;
        req_kill  = 1'b1;
        req_addr  = 32'h500;
        req_be    = 4'b1111;
        req_we    = 1'b0;
        #1;
        chk1("kill stall", stall, 1'b0);
        tick();
        chk1("kill mem_req", mem_req, 1'b0);
        chk1("kill stall2", stall, 1'b0);
        req_kill = 1'b0;
        req_be   = 4'b0000;
        #1;
        chk1("be0 stall", stall, 1'b0);
        tick();
        chk1("be0 mem_req", mem_req, 1'b0);
        req_valid = 1'b0;

        mem_ack = 1'b1;
        tick();
        chk1("idle ack rdata_valid", rdata_valid, 1'b0);
        chk1("idle ack mem_req", mem_req, 1'b0);
        chk("idle ack rdata", rdata, 32'h0000_00F7);
        mem_ack = 1'b0;

        req_valid = 1'b1;
        req_addr  = 32'h504;
        req_be    = 4'b1111;
        tick();
        req_valid = 1'b0;
        #1;
        chk1("rstbusy mem_req pre", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rstbusy mem_req", mem_req, 1'b0);
        chk1("rstbusy stall", stall, 1'b0);
        chk("rstbusy mem_addr", mem_addr, 32'h0);
        tick();
        chk1("rstbusy rdata_valid", rdata_valid, 1'b0);
        reset = 1'b0;
        tick();
        chk1("rstbusy no pulse", rdata_valid, 1'b0);
        chk1("rstbusy idle mem_req", mem_req, 1'b0);

        run_op("lbu2", 32'h402, 4'b0100, 1'b0, 1'b0, 32'h0, 32'h0099_0000,
               1, 32'h400, 32'h0, 32'h0000_0099);

`ifdef LSU_TIMEOUT_EN
        req_valid = 1'b1;
        req_addr  = 32'h600;
        req_be    = 4'b1111;
        req_we    = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk1("to busy mem_req", mem_req, 1'b1);
            chk1("to busy stall", stall, 1'b1);
            tick();
        end
        #1;
        chk1("to mem_req", mem_req, 1'b0);
        chk1("to rdata_valid", rdata_valid, 1'b1);
        chk1("to bus_error", bus_error, 1'b1);
        chk("to rdata", rdata, 32'h0);
        chk1("to stall", stall, 1'b0);
        tick();
        chk1("to post bus_error", bus_error, 1'b0);
        chk1("to post rdata_valid", rdata_valid, 1'b0);
        run_op("to ackwins", 32'h604, 4'b1111, 1'b0, 1'b0, 32'h0,
               32'h0BAD_F00D, 4, 32'h604, 32'h0, 32'h0BAD_F00D);
`else
        run_op("long", 32'h604, 4'b1111, 1'b0, 1'b0, 32'h0,
               32'h0BAD_F00D, 12, 32'h604, 32'h0, 32'h0BAD_F00D);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
